// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
// The optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

  // Bit-counter width for an arbitrary operand width; never narrower than one bit.
  function automatic int unsigned cntWidth(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_nbit_full_adder_cell.sv
// Single combinational full-adder cell; the only arithmetic in the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry for one bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_adder_nbit.sv
// Bit-serial N-bit adder: one result bit per clock, LSB first, start/done handshake.
// Define SERIAL_ADD_SUB_EN to add the 'sub' port (a-b via ~b and carry-in 1,
// with cout reported as borrow).
module serial_adder_nbit
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_lastBit;
  logic [WIDTH-1:0] w_bLoad;
  logic             w_cLoad;
  logic             w_s;
  logic             w_co;
  logic             w_coutFinal;

  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_lastBit = (r_cnt == LAST_BIT);

`ifdef SERIAL_ADD_SUB_EN
  logic r_subMode;

  // Subtraction is addition of ~b with a forced carry-in; remember the mode so
  // the final carry can be inverted into a borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_subMode <= 1'b0;
    else if (w_accept)
      r_subMode <= sub;
  end

  assign w_bLoad     = sub ? ~b : b;
  assign w_cLoad     = sub ? 1'b1 : cin;
  assign w_coutFinal = r_subMode ? ~w_co : w_co;
`else
  assign w_bLoad     = b;
  assign w_cLoad     = cin;
  assign w_coutFinal = w_co;
`endif

  full_adder_cell u_fa (
    .a  (r_aSh[0]),
    .b  (r_bSh[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // Control: accept in IDLE/DONE, walk WIDTH bits in SHIFT, pulse DONE for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) r_state <= SHIFT;
        SHIFT:   if (w_lastBit) r_state <= DONE;
        DONE:    r_state <= w_accept ? SHIFT : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath: load operands on accept, otherwise shift one bit per SHIFT cycle and
  // publish sum/cout only on the final bit so they stay stable between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aSh   <= '0;
      r_bSh   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_aSh   <= a;
      r_bSh   <= w_bLoad;
      r_res   <= '0;
      r_carry <= w_cLoad;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_aSh   <= r_aSh >> 1;
      r_bSh   <= r_bSh >> 1;
      r_res   <= {w_s, r_res[WIDTH-1:1]};
      r_carry <= w_co;
      r_cnt   <= r_cnt + 1'b1;
      if (w_lastBit) begin
        r_sum  <= {w_s, r_res[WIDTH-1:1]};
        r_cout <= w_coutFinal;
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
